// File: rtl/jtag_gpio_bank.sv
// jtag_gpio_bank: scan-addressed GPIO bank (OE/OUT/IN/EDGE) with op-coded updates, clocked on tck
module jtag_gpio_bank #(
    parameter int NR_GPIOS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                tck,
    input  logic                reset_,
    input  logic                tdi,
    output logic                gpios_tdo,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic                scan_n_ir,
    input  logic                extest_ir,
    input  logic [NR_GPIOS-1:0] gpio_inputs,
    output logic [NR_GPIOS-1:0] gpio_outputs,
    output logic [NR_GPIOS-1:0] gpio_outputs_ena
);
    localparam int DW = NR_GPIOS + 2;
    logic [1:0]                            scan_sel, scan_sel_nxt;
    logic [DW-1:0]                         gpio_dr, gpio_dr_nxt;
    logic [SYNC_STAGES-1:0][NR_GPIOS-1:0]  sync_q;
    logic [NR_GPIOS-1:0]                   sync_in, sync_prev, edge_flags, edge_nxt;
    logic [NR_GPIOS-1:0]                   cap_val, clr_mask, out_nxt, oe_nxt, data;
    logic [1:0]                            op;
    logic                                  dr_act, do_cap, do_shift, do_upd;

    function automatic logic [NR_GPIOS-1:0] apply_op(input logic [NR_GPIOS-1:0] r, input logic [1:0] o,
                                                     input logic [NR_GPIOS-1:0] d);
        return o == 2'b01 ? d : o == 2'b10 ? (r | d) : o == 2'b11 ? (r & ~d) : r;
    endfunction

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign op        = gpio_dr[DW-1 -: 2];
    assign data      = gpio_dr[NR_GPIOS-1:0];
    assign dr_act    = extest_ir && !scan_n_ir;
    assign do_cap    = dr_act && capture_dr;
    assign do_shift  = dr_act && shift_dr && !capture_dr;
    assign do_upd    = dr_act && update_dr && !capture_dr && !shift_dr;
    assign gpios_tdo = scan_n_ir ? scan_sel[0] : gpio_dr[0];

    always_comb begin
        cap_val      = scan_sel == 2'd0 ? gpio_outputs_ena : scan_sel == 2'd1 ? gpio_outputs :
                       scan_sel == 2'd2 ? sync_in : edge_flags;
        scan_sel_nxt = scan_n_ir && shift_dr && !capture_dr ? {tdi, scan_sel[1]} : scan_sel;
        gpio_dr_nxt  = do_cap ? {2'b00, cap_val} : do_shift ? {tdi, gpio_dr[DW-1:1]} : gpio_dr;
        oe_nxt       = do_upd && scan_sel == 2'd0 ? apply_op(gpio_outputs_ena, op, data) : gpio_outputs_ena;
        out_nxt      = do_upd && scan_sel == 2'd1 ? apply_op(gpio_outputs, op, data) : gpio_outputs;
        clr_mask     = do_upd && scan_sel == 2'd3 && op != 2'b00 ? data : '0;
        edge_nxt     = (edge_flags & ~clr_mask) | (sync_in ^ sync_prev);
    end

    always_ff @(posedge tck) begin
        if (!reset_) begin
            scan_sel         <= '0;
            gpio_dr          <= '0;
            sync_q           <= '0;
            sync_prev        <= '0;
            edge_flags       <= '0;
            gpio_outputs     <= '0;
            gpio_outputs_ena <= '0;
        end else begin
            scan_sel         <= scan_sel_nxt;
            gpio_dr          <= gpio_dr_nxt;
            sync_q           <= {sync_q[SYNC_STAGES-2:0], gpio_inputs};
            sync_prev        <= sync_in;
            edge_flags       <= edge_nxt;
            gpio_outputs     <= out_nxt;
            gpio_outputs_ena <= oe_nxt;
        end
    end
endmodule
